// File: rtl/pipelined_skip_adder.sv
// Pipelined carry-skip adder/subtractor. Each stage resolves BLK*GRP bits through GRP
// skip blocks. A single global stall (adv) moves the whole valid/data chain in lock-step.
module pipelined_skip_adder #(
  parameter int N   = 32,
  parameter int BLK = 4,
  parameter int GRP = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int SW = BLK * GRP;
  localparam int L  = N / SW;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         carry;
    logic         cmsb;
  } slice_t;

  // Resolves slice k: ripple inside each block, skip mux between blocks.
  // cmsb records the carry into bit N-1 when that bit lies in this slice.
  function automatic slice_t add_slice(
    input logic [N-1:0] av,
    input logic [N-1:0] bv,
    input logic [N-1:0] sum_in,
    input logic         cin_in,
    input logic         cmsb_in,
    input int           k
  );
    slice_t r;
    logic   blk_cin;
    logic   rc;
    logic   prop;
    int     idx;
    r.sum  = sum_in;
    r.cmsb = cmsb_in;
    rc     = cin_in;
    for (int g = 0; g < GRP; g++) begin
      blk_cin = rc;
      prop    = 1'b1;
      for (int i = 0; i < BLK; i++) begin
        idx = k * SW + g * BLK + i;
        if (idx == N - 1) r.cmsb = rc;
        r.sum[idx] = av[idx] ^ bv[idx] ^ rc;
        rc         = (av[idx] & bv[idx]) | ((av[idx] ^ bv[idx]) & rc);
        prop       = prop & (av[idx] ^ bv[idx]);
      end
      rc = rc | (prop & blk_cin);
    end
    r.carry = rc;
    return r;
  endfunction

  logic         stg_valid_q [L];
  logic         stg_valid_d [L];
  logic         stg_carry_q [L];
  logic         stg_carry_d [L];
  logic         stg_cmsb_q  [L];
  logic         stg_cmsb_d  [L];
  logic [N-1:0] stg_sum_q   [L];
  logic [N-1:0] stg_sum_d   [L];
  logic [N-1:0] stg_a_q     [L];
  logic [N-1:0] stg_a_d     [L];
  logic [N-1:0] stg_b_q     [L];
  logic [N-1:0] stg_b_d     [L];

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] sum_q, sum_d;
  logic         cout_q, cout_d;
  logic         ovf_q, ovf_d;

  logic         adv;
  slice_t       step [L];

  // Stage 0 captures the raw beat with b already inverted for subtraction;
  // stage k+1 (or the output register) receives stage k with slice k resolved.
  always_comb begin
    adv = ~out_valid_q | out_ready;

    for (int k = 0; k < L; k++) begin
      step[k] = add_slice(stg_a_q[k], stg_b_q[k], stg_sum_q[k],
                          stg_carry_q[k], stg_cmsb_q[k], k);
      stg_valid_d[k] = stg_valid_q[k];
      stg_carry_d[k] = stg_carry_q[k];
      stg_cmsb_d[k]  = stg_cmsb_q[k];
      stg_sum_d[k]   = stg_sum_q[k];
      stg_a_d[k]     = stg_a_q[k];
      stg_b_d[k]     = stg_b_q[k];
    end

    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;

    if (adv) begin
      stg_valid_d[0] = in_valid;
      stg_carry_d[0] = sub | cin;
      stg_cmsb_d[0]  = 1'b0;
      stg_sum_d[0]   = '0;
      stg_a_d[0]     = a;
      stg_b_d[0]     = sub ? ~b : b;

      for (int k = 1; k < L; k++) begin
        stg_valid_d[k] = stg_valid_q[k-1];
        stg_carry_d[k] = step[k-1].carry;
        stg_cmsb_d[k]  = step[k-1].cmsb;
        stg_sum_d[k]   = step[k-1].sum;
        stg_a_d[k]     = stg_a_q[k-1];
        stg_b_d[k]     = stg_b_q[k-1];
      end

      // Bubbles clear out_valid but leave the last result on the data outputs.
      out_valid_d = stg_valid_q[L-1];
      if (stg_valid_q[L-1]) begin
        sum_d  = step[L-1].sum;
        cout_d = step[L-1].carry;
        ovf_d  = step[L-1].cmsb ^ step[L-1].carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < L; k++) stg_valid_q[k] <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      for (int k = 0; k < L; k++) stg_valid_q[k] <= stg_valid_d[k];
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  // Datapath contents are qualified by the valid chain, so they need no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < L; k++) begin
      stg_carry_q[k] <= stg_carry_d[k];
      stg_cmsb_q[k]  <= stg_cmsb_d[k];
      stg_sum_q[k]   <= stg_sum_d[k];
      stg_a_q[k]     <= stg_a_d[k];
      stg_b_q[k]     <= stg_b_d[k];
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
